// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit: ALU operation codes, the LSU
// state encoding, access-size classification and small decode helpers.
// ----------------------------------------------------------------------------
package load_store_unit_pkg;

    // ALU operation codes (6-bit alucode)
    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_SUB = 6'd1;
    localparam logic [5:0] ALU_AND = 6'd2;
    localparam logic [5:0] ALU_OR  = 6'd3;
    localparam logic [5:0] ALU_XOR = 6'd4;
    localparam logic [5:0] ALU_SLL = 6'd5;
    localparam logic [5:0] ALU_LB  = 6'd16;
    localparam logic [5:0] ALU_LH  = 6'd17;
    localparam logic [5:0] ALU_LW  = 6'd18;
    localparam logic [5:0] ALU_LBU = 6'd19;
    localparam logic [5:0] ALU_LHU = 6'd20;
    localparam logic [5:0] ALU_SB  = 6'd21;
    localparam logic [5:0] ALU_SH  = 6'd22;
    localparam logic [5:0] ALU_SW  = 6'd23;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_e;

    function automatic acc_size_e acc_size(input logic [5:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: return SZ_BYTE;
            ALU_LH, ALU_LHU, ALU_SH: return SZ_HALF;
            ALU_LW, ALU_SW:          return SZ_WORD;
            default:                 return SZ_NONE;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return acc_size(op) != SZ_NONE;
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    function automatic logic is_signed_load(input logic [5:0] op);
        return (op == ALU_LB) || (op == ALU_LH);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Word-wide data-memory request/ack bus.
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = store
//   mem_addr  : word-aligned address
//   mem_be    : byte enables
//   mem_wdata : store data, replicated into byte lanes
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : one-cycle completion
// master = load/store unit, slave = memory.
// ----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit_align.sv
// ----------------------------------------------------------------------------
// load_store_unit_align
// Combinational byte-lane logic for the load/store unit.
//   i_alucode    : operation code
//   i_addr_lo    : address bits [1:0]
//   i_store_data : rs2 value for stores
//   i_mem_rdata  : raw read word from memory
//   o_mem_be     : byte enables (0 for non-memory ops)
//   o_mem_wdata  : store data replicated into lanes (0 for non-stores)
//   o_load_data  : selected lane, sign/zero-extended
//   o_misalign   : access crosses its natural alignment
// ----------------------------------------------------------------------------
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [5:0]  i_alucode,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    // Only the low halfword of the shifted word is ever selected.
    logic [15:0]        w_lane;
    logic signed [7:0]  w_lane_b;
    logic signed [15:0] w_lane_h;
    logic               w_store;
    logic               w_sext;

    assign w_lane   = 16'(i_mem_rdata >> {i_addr_lo, 3'b000});
    assign w_lane_b = w_lane[7:0];
    assign w_lane_h = w_lane;
    assign w_store  = is_store_op(i_alucode);
    assign w_sext   = is_signed_load(i_alucode);

    always_comb begin
        o_mem_be    = 4'b0000;
        o_mem_wdata = 32'h0;
        o_load_data = 32'h0;
        o_misalign  = 1'b0;
        case (acc_size(i_alucode))
            SZ_BYTE: begin
                o_mem_be    = 4'b0001 << i_addr_lo;
                o_mem_wdata = w_store ? {4{i_store_data[7:0]}} : 32'h0;
                o_load_data = w_sext ? 32'(w_lane_b) : {24'h0, w_lane_b};
            end
            SZ_HALF: begin
                o_misalign  = i_addr_lo[0];
                o_mem_be    = 4'b0011 << i_addr_lo;
                o_mem_wdata = w_store ? {2{i_store_data[15:0]}} : 32'h0;
                o_load_data = w_sext ? 32'(w_lane_h) : {16'h0, w_lane_h};
            end
            SZ_WORD: begin
                o_misalign  = |i_addr_lo;
                o_mem_be    = 4'b1111;
                o_mem_wdata = w_store ? i_store_data : 32'h0;
                o_load_data = i_mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-access stage after the ALU. Loads/stores go out on the memory bus
// with byte enables; loads come back aligned and extended. Other ops pass
// alu_result straight through. One op in flight; in_ready only in IDLE.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : upstream handshake
//   alucode, alu_result,
//   store_data, rd_in       : operation from the ALU
//   out_valid, out_data,
//   out_rd, out_misalign,
//   out_buserr              : one-cycle completion to writeback
//   mem                     : data-memory bus (master side)
// ----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            alucode,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           store_data,
    input  logic [4:0]            rd_in,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic [4:0]            out_rd,
    output logic                  out_misalign,
    output logic                  out_buserr,
    load_store_unit_if.master     mem
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       r_state;
    logic [5:0]       r_op;
    logic [1:0]       r_addr_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [4:0]       r_out_rd;
    logic             r_out_misalign;
    logic             r_out_buserr;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_mem_wdata;

    logic [5:0]       w_op;
    logic [1:0]       w_addr_lo;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load;
    logic             w_misalign;

    // In IDLE the lane logic decodes the incoming op so be/wdata/misalign can
    // be registered at acceptance; afterwards it decodes the latched op so the
    // returning read word is aligned against the original address.
    assign w_op      = (r_state == LSU_IDLE) ? alucode : r_op;
    assign w_addr_lo = (r_state == LSU_IDLE) ? alu_result[1:0] : r_addr_lo;

    load_store_unit_align u_align (
        .i_alucode    (w_op),
        .i_addr_lo    (w_addr_lo),
        .i_store_data (store_data),
        .i_mem_rdata  (mem.mem_rdata),
        .o_mem_be     (w_be),
        .o_mem_wdata  (w_wdata),
        .o_load_data  (w_load),
        .o_misalign   (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= LSU_IDLE;
            r_op           <= 6'h0;
            r_addr_lo      <= 2'b00;
            r_cnt          <= '0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_data     <= 32'h0;
            r_out_rd       <= 5'h0;
            r_out_misalign <= 1'b0;
            r_out_buserr   <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= 32'h0;
            r_mem_be       <= 4'b0000;
            r_mem_wdata    <= 32'h0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (in_valid) begin
                        r_op       <= alucode;
                        r_addr_lo  <= alu_result[1:0];
                        r_out_rd   <= rd_in;
                        r_in_ready <= 1'b0;
                        if (!is_mem_op(alucode)) begin
                            r_out_data  <= alu_result;
                            r_out_valid <= 1'b1;
                            r_state     <= LSU_RESP;
                        end else if (w_misalign) begin
                            r_out_data     <= 32'h0;
                            r_out_misalign <= 1'b1;
                            r_out_valid    <= 1'b1;
                            r_state        <= LSU_RESP;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= is_store_op(alucode);
                            r_mem_addr  <= {alu_result[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_cnt       <= '0;
                            r_state     <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem.mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_out_data  <= is_store_op(r_op) ? 32'h0 : w_load;
                        r_out_valid <= 1'b1;
                        r_state     <= LSU_RESP;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_out_data   <= 32'h0;
                        r_out_buserr <= 1'b1;
                        r_out_valid  <= 1'b1;
                        r_state      <= LSU_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LSU_RESP: begin
                    // Fault flags are meaningful only alongside out_valid.
                    r_out_valid    <= 1'b0;
                    r_out_misalign <= 1'b0;
                    r_out_buserr   <= 1'b0;
                    r_in_ready     <= 1'b1;
                    r_state        <= LSU_IDLE;
                end
                default: begin
                    r_state    <= LSU_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_rd        = r_out_rd;
    assign out_misalign  = r_out_misalign;
    assign out_buserr    = r_out_buserr;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_be    = r_mem_be;
    assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: directed cases plus randomized operations compared
// against a byte-arithmetic reference model of the load/store rules.
// ----------------------------------------------------------------------------
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  alucode = 6'h0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [4:0]  rd_in = 5'h0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_misalign;
    logic        out_buserr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] last_data;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;

    load_store_unit_if mem_if ();

    load_store_unit #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alucode      (alucode),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd_in        (rd_in),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_misalign (out_misalign),
        .out_buserr   (out_buserr),
        .mem          (mem_if.master)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [5:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: return 1;
            ALU_LH, ALU_LHU, ALU_SH: return 2;
            ALU_LW, ALU_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return op == ALU_SB || op == ALU_SH || op == ALU_SW;
    endfunction

    function automatic bit op_signed(input logic [5:0] op);
        return op == ALU_LB || op == ALU_LH;
    endfunction

    function automatic logic [3:0] exp_be(input int sz, input int off);
        int b;
        b = ((1 << sz) - 1) << off;
        return b[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] sd);
        logic [31:0] wd;
        logic [31:0] t;
        wd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            t = sd >> (8 * (i % sz));
            wd[8*i +: 8] = t[7:0];
        end
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input int off, input logic [31:0] rdata);
        int          sz;
        logic [31:0] sh;
        longint      v;
        longint      full;
        sz = op_size(op);
        sh = rdata >> (8 * off);
        v  = longint'(sh);
        if (sz < 4) begin
            full = longint'(1) << (8 * sz);
            v = v % full;
            if (op_signed(op) && v >= full / 2) v = v - full;
        end
        return v[31:0];
    endfunction

    // Issue one op and follow it to completion. d = cycle (1-based) of the
    // REQ phase in which the memory acks; d = 0 means memory never answers.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdata, input logic [4:0] rd, input int d);
        int          sz;
        int          off;
        int          n;
        bit          mis;
        bit          st;
        logic [31:0] exp_d;
        sz  = op_size(op);
        off = int'(a[1:0]);
        st  = op_store(op);
        mis = (sz != 0) && ((off % sz) != 0);
        @(negedge clk);
        in_valid   = 1'b1;
        alucode    = op;
        alu_result = a;
        store_data = sd;
        rd_in      = rd;
        @(negedge clk);
        in_valid   = 1'b0;
        alucode    = 6'($urandom);
        alu_result = $urandom;
        store_data = $urandom;
        check_val("busy_ready", 32'(in_ready), 32'd0);
        if (sz == 0 || mis) begin
            exp_d = (sz == 0) ? a : 32'h0;
            check_val("no_req", 32'(mem_if.mem_req), 32'd0);
        end else begin
            n = (d == 0) ? TO : d;
            for (int i = 1; i <= n; i++) begin
                check_val("req_held", 32'(mem_if.mem_req), 32'd1);
                check_val("req_we", 32'(mem_if.mem_we), 32'(st));
                check_val("req_addr", mem_if.mem_addr, {a[31:2], 2'b00});
                check_val("req_be", 32'(mem_if.mem_be), 32'(exp_be(sz, off)));
                if (st) check_val("req_wdata", mem_if.mem_wdata, exp_wdata(sz, sd));
                check_val("req_nvalid", 32'(out_valid), 32'd0);
                check_val("req_ready", 32'(in_ready), 32'd0);
                last_be    = mem_if.mem_be;
                last_wdata = mem_if.mem_wdata;
                if (d != 0 && i == d) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = rdata;
                end
                @(negedge clk);
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = $urandom;
            end
            exp_d = (d == 0 || st) ? 32'h0 : exp_load(op, off, rdata);
            check_val("req_drop", 32'(mem_if.mem_req), 32'd0);
        end
        check_val("out_valid", 32'(out_valid), 32'd1);
        check_val("out_data", out_data, exp_d);
        check_val("out_rd", 32'(out_rd), 32'(rd));
        check_val("out_misalign", 32'(out_misalign), 32'(mis));
        check_val("out_buserr", 32'(out_buserr), 32'(sz != 0 && !mis && d == 0));
        check_val("resp_ready", 32'(in_ready), 32'd0);
        last_data = out_data;
        if (d == 0) mem_if.mem_ack = 1'b1;   // late ack after timeout
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        check_val("valid_pulse", 32'(out_valid), 32'd0);
        check_val("idle_ready", 32'(in_ready), 32'd1);
        if (d == 0) begin
            @(negedge clk);
            check_val("late_ack_ign", 32'(out_valid), 32'd0);
            check_val("late_ack_req", 32'(mem_if.mem_req), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0]  ops [14];
        logic [31:0] ra;
        ops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLL, ALU_LB, ALU_LH, ALU_LW,
                ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW, ALU_LW, ALU_SW};
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_val("rst_req", 32'(mem_if.mem_req), 32'd0);
        check_val("rst_we", 32'(mem_if.mem_we), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", out_data, 32'h0);
        check_val("rst_rd", 32'(out_rd), 32'd0);
        check_val("rst_flags", 32'({out_misalign, out_buserr}), 32'd0);
        check_val("rst_addr", mem_if.mem_addr, 32'h0);
        check_val("rst_be", 32'(mem_if.mem_be), 32'd0);
        check_val("rst_wdata", mem_if.mem_wdata, 32'h0);
        rst = 1'b0;

        // Directed cases
        run_op(ALU_ADD, 32'h1234, 32'h0, 32'h0, 5'd5, 1);
        check_val("add_data", last_data, 32'h1234);
        run_op(ALU_SB, 32'h103, 32'hAB, 32'h0, 5'd7, 1);
        check_val("sb_be", 32'(last_be), 32'h8);
        check_val("sb_wdata", last_wdata, 32'hABABABAB);
        run_op(ALU_SB, 32'h103, 32'hAB, 32'h0, 5'd8, 4);
        run_op(ALU_LB, 32'h102, 32'h0, 32'h0080_0000, 5'd9, 1);
        check_val("lb_sext", last_data, 32'hFFFF_FF80);
        run_op(ALU_LBU, 32'h102, 32'h0, 32'h0080_0000, 5'd10, 2);
        check_val("lbu_zext", last_data, 32'h0000_0080);
        run_op(ALU_LW, 32'h102, 32'h0, 32'h0, 5'd11, 1);
        run_op(ALU_LW, 32'h200, 32'h0, 32'h0, 5'd12, 0);

        // Reset while in REQ discards the pending op
        @(negedge clk);
        in_valid = 1'b1; alucode = ALU_LW; alu_result = 32'h300; rd_in = 5'd13;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("rstreq_req", 32'(mem_if.mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rstreq_drop", 32'(mem_if.mem_req), 32'd0);
        check_val("rstreq_valid", 32'(out_valid), 32'd0);
        check_val("rstreq_ready", 32'(in_ready), 32'd1);
        mem_if.mem_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        repeat (2) begin
            check_val("rstreq_noval", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Randomized operations
        for (int k = 0; k < 80; k++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            run_op(ops[$urandom_range(0, 13)], ra, $urandom, $urandom,
                   5'($urandom), $urandom_range(1, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
